// File: rtl/membus_pkg.sv
// rtl/membus_pkg.sv - widths, arbiter states and slot record shared by membus_arbiter
package membus_pkg;

  localparam int AW = 20;
  localparam int DW = 64;
  localparam int TW = 8;

  typedef enum logic [1:0] {IDLE, ISSUE, DONE} state_t;

  typedef struct packed {
    logic          pending;
    logic          is_write;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [TW-1:0] wtag;
  } slot_t;

endpackage

// File: rtl/membus_port.sv
// rtl/membus_port.sv - per-master strobe capture, write-data phase and wait line
module membus_port
  import membus_pkg::*;
(
  input  logic          clk,
  input  logic          reset,
  input  logic [DW-1:0] ad,
  input  logic [TW-1:0] tag,
  input  logic          astb,
  input  logic          rd,
  input  logic          wr,
  input  logic          acked,
  input  logic          clr,
  output slot_t         slot,
  output logic          stall
);

  logic wphase;
  logic accept;

  // A slot being cleared this cycle may be refilled; the new capture wins.
  assign accept = astb && (rd ^ wr) && !wphase && (!slot.pending || clr);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      slot   <= '0;
      wphase <= 1'b0;
      stall  <= 1'b0;
    end else if (accept) begin
      slot.addr     <= ad[AW-1:0];
      slot.is_write <= wr;
      slot.pending  <= rd;
      wphase        <= wr;
      stall         <= 1'b1;
    end else begin
      if (wphase) begin
        slot.wdata   <= ad;
        slot.wtag    <= tag;
        slot.pending <= 1'b1;
        wphase       <= 1'b0;
      end else if (clr) begin
        slot.pending <= 1'b0;
      end
      // Dropped on the ack edge so the wait line is already low in DONE.
      if (acked) stall <= 1'b0;
    end
  end

endmodule

// File: rtl/membus_arbiter.sv
// rtl/membus_arbiter.sv - two-master round-robin arbiter onto a single memory port
module membus_arbiter
  import membus_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic [1:0][DW-1:0] m_ad,
  input  logic [1:0][TW-1:0] m_tag,
  input  logic [1:0]         m_astb,
  input  logic [1:0]         m_rd,
  input  logic [1:0]         m_wr,
  output logic [1:0]         m_wait,
  output logic [1:0]         m_dvalid,
  output logic [DW-1:0]      m_data,
  output logic [TW-1:0]      m_dtag,
  output logic               mem_req,
  output logic               mem_we,
  output logic [AW-1:0]      mem_addr,
  output logic [DW-1:0]      mem_wdata,
  output logic [TW-1:0]      mem_wtag,
  input  logic               mem_ack,
  input  logic [DW-1:0]      mem_rdata,
  input  logic [TW-1:0]      mem_rtag
);

  state_t     state, state_n;
  logic       gnt, gnt_n, last;
  slot_t      slot [2];
  logic [1:0] acked, clr;

  for (genvar i = 0; i < 2; i++) begin : g_port
    assign acked[i] = (state == ISSUE) && mem_ack && (gnt == 1'(i));
    assign clr[i]   = (state == DONE) && (gnt == 1'(i));

    membus_port u_port (
      .clk   (clk),
      .reset (reset),
      .ad    (m_ad[i]),
      .tag   (m_tag[i]),
      .astb  (m_astb[i]),
      .rd    (m_rd[i]),
      .wr    (m_wr[i]),
      .acked (acked[i]),
      .clr   (clr[i]),
      .slot  (slot[i]),
      .stall (m_wait[i])
    );
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      gnt   <= 1'b0;
    end else begin
      state <= state_n;
      gnt   <= gnt_n;
    end
  end

  always_comb begin
    state_n = state;
    gnt_n   = gnt;
    case (state)
      IDLE: begin
        if (slot[0].pending || slot[1].pending) begin
          state_n = ISSUE;
          // On a tie the master that was not served last goes first.
          if (slot[0].pending && slot[1].pending) gnt_n = ~last;
          else                                    gnt_n = slot[1].pending;
        end
      end
      ISSUE:   if (mem_ack) state_n = DONE;
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      last      <= 1'b1;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_wtag  <= '0;
      m_dvalid  <= '0;
      m_data    <= '0;
      m_dtag    <= '0;
    end else begin
      m_dvalid <= '0;
      if (state == IDLE && state_n == ISSUE) begin
        last      <= gnt_n;
        mem_req   <= 1'b1;
        mem_we    <= slot[gnt_n].is_write;
        mem_addr  <= slot[gnt_n].addr;
        mem_wdata <= slot[gnt_n].wdata;
        mem_wtag  <= slot[gnt_n].wtag;
      end
      if (state == ISSUE && mem_ack) begin
        mem_req <= 1'b0;
        if (!mem_we) begin
          m_data        <= mem_rdata;
          m_dtag        <= mem_rtag;
          m_dvalid[gnt] <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_membus_arbiter.sv
// tb/tb_membus_arbiter.sv - randomized self-checking bench for membus_arbiter
module tb_membus_arbiter;
  import membus_pkg::*;

  logic               clk = 1'b0;
  logic               reset = 1'b0;
  logic [1:0][DW-1:0] m_ad = '0;
  logic [1:0][TW-1:0] m_tag = '0;
  logic [1:0]         m_astb = '0;
  logic [1:0]         m_rd = '0;
  logic [1:0]         m_wr = '0;
  logic [1:0]         m_wait;
  logic [1:0]         m_dvalid;
  logic [DW-1:0]      m_data;
  logic [TW-1:0]      m_dtag;
  logic               mem_req;
  logic               mem_we;
  logic [AW-1:0]      mem_addr;
  logic [DW-1:0]      mem_wdata;
  logic [TW-1:0]      mem_wtag;
  logic               mem_ack = 1'b0;
  logic [DW-1:0]      mem_rdata = '0;
  logic [TW-1:0]      mem_rtag = '0;

  membus_arbiter dut (
    .clk(clk), .reset(reset), .m_ad(m_ad), .m_tag(m_tag), .m_astb(m_astb),
    .m_rd(m_rd), .m_wr(m_wr), .m_wait(m_wait), .m_dvalid(m_dvalid),
    .m_data(m_data), .m_dtag(m_dtag), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wtag(mem_wtag),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata), .mem_rtag(mem_rtag)
  );

  initial forever #5 clk = ~clk;

  typedef struct {
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [TW-1:0] wtag;
    logic [DW-1:0] rdata;
    logic [TW-1:0] rtag;
    int            req_cycle;
    int            ack_cycle;
    int            held;
    bit            stable;
  } txn_t;

  typedef struct {
    int            m;
    logic [DW-1:0] data;
    logic [TW-1:0] tag;
    int            cycle;
  } dv_t;

  typedef struct {
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [TW-1:0] wtag;
  } op_t;

  txn_t                 txq[$];
  dv_t                  dvq[$];
  logic [DW+TW-1:0]     rdq[$];
  txn_t                 cur;
  int                   n_checks = 0;
  int                   n_fail = 0;
  int                   cyc = 0;
  int                   age = 0;
  int                   cur_delay = 0;
  int                   mem_delay = 0;
  bit                   rand_delay = 1'b0;
  bit                   rr_last = 1'b1;

  // One clock: log read returns and completed memory transactions, act as memory.
  task automatic step();
    dv_t d;
    @(posedge clk);
    #1;
    cyc++;
    for (int i = 0; i < 2; i++) begin
      if (m_dvalid[i] === 1'b1) begin
        d.m = i; d.data = m_data; d.tag = m_dtag; d.cycle = cyc;
        dvq.push_back(d);
      end
    end
    mem_ack = 1'b0;
    if (mem_req === 1'b1) begin
      if (age == 0) begin
        cur.we = mem_we; cur.addr = mem_addr; cur.wdata = mem_wdata; cur.wtag = mem_wtag;
        cur.req_cycle = cyc; cur.held = 0; cur.stable = 1'b1;
        cur_delay = rand_delay ? int'($urandom_range(0, 3)) : mem_delay;
      end else if ({mem_we, mem_addr, mem_wdata, mem_wtag} !== {cur.we, cur.addr, cur.wdata, cur.wtag}) begin
        cur.stable = 1'b0;
      end
      cur.held++;
      if (age == cur_delay) begin
        mem_ack = 1'b1;
        if (rdq.size() > 0) {mem_rdata, mem_rtag} = rdq.pop_front();
        else begin
          mem_rdata = {$urandom, $urandom};
          mem_rtag  = 8'($urandom);
        end
        cur.rdata = mem_rdata; cur.rtag = mem_rtag; cur.ack_cycle = cyc;
        txq.push_back(cur);
        age = 0;
      end else begin
        age++;
      end
    end else begin
      age = 0;
      if (rand_delay && $urandom_range(0, 3) == 0) mem_ack = 1'b1;
    end
  endtask

  task automatic clear_inputs();
    m_astb = '0; m_rd = '0; m_wr = '0;
  endtask

  task automatic clear_logs();
    txq.delete(); dvq.delete(); rdq.delete();
  endtask

  task automatic test_reset();
    reset = 1'b0;
    clear_inputs();
    repeat (3) step();
    n_checks++;
    if (m_wait !== 2'b00 || m_dvalid !== 2'b00) begin
      n_fail++; $display("FAIL reset_master_lines: wait=%b dvalid=%b want 00 00", m_wait, m_dvalid);
    end
    n_checks++;
    if ({mem_req, mem_we, mem_addr, mem_wdata, mem_wtag} !== '0) begin
      n_fail++; $display("FAIL reset_mem_port: req=%b we=%b addr=%h wdata=%h wtag=%h want all 0", mem_req, mem_we, mem_addr, mem_wdata, mem_wtag);
    end
    n_checks++;
    if (m_data !== '0 || m_dtag !== '0) begin
      n_fail++; $display("FAIL reset_read_data: data=%h tag=%h want 0", m_data, m_dtag);
    end
    reset = 1'b1;
    rr_last = 1'b1;
    repeat (2) step();
  endtask

  task automatic test_read_zero_wait();
    logic w [8];
    int   n;
    clear_logs();
    rdq.push_back({64'h0123456789ABCDEF, 8'h35});
    mem_delay = 0; rand_delay = 1'b0;
    n = cyc;
    m_astb[0] = 1'b1; m_rd[0] = 1'b1; m_ad[0] = 64'h00123;
    w[0] = m_wait[0];
    for (int k = 1; k < 8; k++) begin
      step();
      if (k == 1) clear_inputs();
      w[k] = m_wait[0];
    end
    n_checks++;
    if (txq.size() != 1) begin
      n_fail++; $display("FAIL rd_txn_count: got %0d want 1", txq.size());
    end else begin
      n_checks++;
      if (txq[0].req_cycle != n + 2) begin
        n_fail++; $display("FAIL rd_req_cycle: got N+%0d want N+2", txq[0].req_cycle - n);
      end
      n_checks++;
      if (txq[0].we !== 1'b0 || txq[0].addr !== 20'h00123) begin
        n_fail++; $display("FAIL rd_req_fields: we=%b addr=%h want 0 00123", txq[0].we, txq[0].addr);
      end
    end
    n_checks++;
    if (dvq.size() != 1) begin
      n_fail++; $display("FAIL rd_dvalid_count: got %0d want 1", dvq.size());
    end else begin
      n_checks++;
      if (dvq[0].m != 0 || dvq[0].cycle != n + 3 || dvq[0].data !== 64'h0123456789ABCDEF || dvq[0].tag !== 8'h35) begin
        n_fail++; $display("FAIL rd_dvalid: master=%0d cycle=N+%0d data=%h tag=%h want 0 N+3 0123456789abcdef 35",
                           dvq[0].m, dvq[0].cycle - n, dvq[0].data, dvq[0].tag);
      end
    end
    n_checks++;
    if ({w[0], w[1], w[2], w[3]} !== 4'b0110) begin
      n_fail++; $display("FAIL rd_wait_window: N..N+3=%b%b%b%b want 0110", w[0], w[1], w[2], w[3]);
    end
    n_checks++;
    if (m_data !== 64'h0123456789ABCDEF || m_dtag !== 8'h35) begin
      n_fail++; $display("FAIL rd_data_hold: data=%h tag=%h want 0123456789abcdef 35", m_data, m_dtag);
    end
    rr_last = 1'b0;
  endtask

  task automatic test_write_delayed();
    logic w [12];
    int   n;
    clear_logs();
    mem_delay = 3; rand_delay = 1'b0;
    n = cyc;
    m_astb[1] = 1'b1; m_wr[1] = 1'b1; m_ad[1] = 64'h7FFFF; m_tag[1] = 8'hAA;
    w[0] = m_wait[1];
    for (int k = 1; k < 12; k++) begin
      step();
      if (k == 1) begin
        clear_inputs();
        m_ad[1] = 64'hFFFF0000FFFF0000; m_tag[1] = 8'h3F;
      end else begin
        m_ad[1] = {$urandom, $urandom}; m_tag[1] = 8'($urandom);
      end
      w[k] = m_wait[1];
    end
    n_checks++;
    if (txq.size() != 1) begin
      n_fail++; $display("FAIL wr_txn_count: got %0d want 1", txq.size());
    end else begin
      n_checks++;
      if (txq[0].req_cycle != n + 3 || txq[0].held != 4 || txq[0].ack_cycle != n + 6) begin
        n_fail++; $display("FAIL wr_timing: req=N+%0d held=%0d ack=N+%0d want N+3 4 N+6",
                           txq[0].req_cycle - n, txq[0].held, txq[0].ack_cycle - n);
      end
      n_checks++;
      if (!txq[0].stable || txq[0].we !== 1'b1 || txq[0].addr !== 20'h7FFFF ||
          txq[0].wdata !== 64'hFFFF0000FFFF0000 || txq[0].wtag !== 8'h3F) begin
        n_fail++; $display("FAIL wr_fields: stable=%0d we=%b addr=%h wdata=%h wtag=%h want 1 1 7ffff ffff0000ffff0000 3f",
                           txq[0].stable, txq[0].we, txq[0].addr, txq[0].wdata, txq[0].wtag);
      end
    end
    n_checks++;
    if ({w[0], w[1], w[6], w[7]} !== 4'b0110) begin
      n_fail++; $display("FAIL wr_wait_window: N,N+1,N+6,N+7=%b%b%b%b want 0110", w[0], w[1], w[6], w[7]);
    end
    n_checks++;
    if (dvq.size() != 0) begin
      n_fail++; $display("FAIL wr_no_dvalid: got %0d pulses want 0", dvq.size());
    end
    rr_last = 1'b1;
  endtask

  task automatic test_round_robin();
    for (int r = 0; r < 5; r++) begin
      logic [AW-1:0] a [2];
      int            first;
      int            t;
      clear_logs();
      mem_delay = r % 3; rand_delay = 1'b0;
      for (int i = 0; i < 2; i++) begin
        a[i] = AW'($urandom);
        a[i][0] = 1'(i);
        m_ad[i] = {$urandom, $urandom};
        m_ad[i][AW-1:0] = a[i];
        m_astb[i] = 1'b1; m_rd[i] = 1'b1;
      end
      first = rr_last ? 0 : 1;
      step();
      clear_inputs();
      t = 0;
      while (dvq.size() < 2 && t < 40) begin
        step();
        t++;
      end
      n_checks++;
      if (dvq.size() != 2 || txq.size() != 2) begin
        n_fail++; $display("FAIL rr_complete round %0d: dvalids=%0d txns=%0d want 2 2", r, dvq.size(), txq.size());
      end else begin
        n_checks++;
        if (txq[0].addr !== a[first] || txq[1].addr !== a[1-first]) begin
          n_fail++; $display("FAIL rr_order round %0d: addrs %h,%h want %h,%h", r, txq[0].addr, txq[1].addr, a[first], a[1-first]);
        end
        n_checks++;
        if (dvq[0].m != first || dvq[1].m != 1 - first) begin
          n_fail++; $display("FAIL rr_dv_master round %0d: got %0d,%0d want %0d,%0d", r, dvq[0].m, dvq[1].m, first, 1 - first);
        end
        n_checks++;
        if (dvq[0].data !== txq[0].rdata || dvq[0].tag !== txq[0].rtag ||
            dvq[1].data !== txq[1].rdata || dvq[1].tag !== txq[1].rtag) begin
          n_fail++; $display("FAIL rr_dv_data round %0d: got %h/%h %h/%h want %h/%h %h/%h", r,
                             dvq[0].data, dvq[0].tag, dvq[1].data, dvq[1].tag,
                             txq[0].rdata, txq[0].rtag, txq[1].rdata, txq[1].rtag);
        end
      end
      rr_last = (first == 0);
    end
  endtask

  task automatic test_ignored();
    bit any_wait;
    int t;
    clear_logs();
    mem_delay = 0; rand_delay = 1'b0;
    m_astb = 2'b11; m_rd = 2'b01; m_wr = 2'b01;
    any_wait = 1'b0;
    for (int k = 0; k < 6; k++) begin
      step();
      clear_inputs();
      if (m_wait !== 2'b00) any_wait = 1'b1;
    end
    n_checks++;
    if (any_wait || txq.size() != 0) begin
      n_fail++; $display("FAIL ign_bad_op: wait_seen=%0d txns=%0d want 0 0", any_wait, txq.size());
    end
    mem_delay = 4;
    m_astb[0] = 1'b1; m_rd[0] = 1'b1; m_ad[0] = 64'h0AAAA;
    step();
    clear_inputs();
    step();
    m_astb[0] = 1'b1; m_rd[0] = 1'b1; m_ad[0] = 64'h05555;
    step();
    m_rd[0] = 1'b0; m_wr[0] = 1'b1; m_ad[0] = 64'h03333;
    step();
    clear_inputs();
    t = 0;
    while (dvq.size() < 1 && t < 30) begin
      step();
      t++;
    end
    repeat (6) step();
    n_checks++;
    if (txq.size() != 1) begin
      n_fail++; $display("FAIL ign_pending_count: got %0d txns want 1", txq.size());
    end else begin
      n_checks++;
      if (txq[0].addr !== 20'h0AAAA || txq[0].we !== 1'b0 || !txq[0].stable) begin
        n_fail++; $display("FAIL ign_pending_slot: addr=%h we=%b stable=%0d want 0aaaa 0 1", txq[0].addr, txq[0].we, txq[0].stable);
      end
    end
    n_checks++;
    if (dvq.size() != 1) begin
      n_fail++; $display("FAIL ign_dvalid_count: got %0d want 1", dvq.size());
    end
    rr_last = 1'b0;
  endtask

  task automatic test_reset_mid();
    int t;
    clear_logs();
    mem_delay = 20; rand_delay = 1'b0;
    m_astb[1] = 1'b1; m_rd[1] = 1'b1; m_ad[1] = 64'h00ABC;
    step();
    clear_inputs();
    t = 0;
    while (mem_req !== 1'b1 && t < 10) begin
      step();
      t++;
    end
    n_checks++;
    if (mem_req !== 1'b1) begin
      n_fail++; $display("FAIL rm_req_seen: mem_req=%b want 1", mem_req);
    end
    #2;
    reset = 1'b0;
    #1;
    n_checks++;
    if ({mem_req, mem_we, mem_addr, mem_wdata, mem_wtag} !== '0 || m_wait !== 2'b00 ||
        m_dvalid !== 2'b00 || m_data !== '0 || m_dtag !== '0) begin
      n_fail++; $display("FAIL rm_async_clear: req=%b addr=%h wait=%b dvalid=%b data=%h tag=%h want all 0",
                         mem_req, mem_addr, m_wait, m_dvalid, m_data, m_dtag);
    end
    mem_ack = 1'b0;
    repeat (2) step();
    reset = 1'b1;
    rr_last = 1'b1;
    step();
    clear_logs();
    mem_delay = 0;
    m_astb = 2'b11; m_rd = 2'b11;
    m_ad[0] = 64'h00100; m_ad[1] = 64'h00201;
    step();
    clear_inputs();
    t = 0;
    while (dvq.size() < 2 && t < 30) begin
      step();
      t++;
    end
    n_checks++;
    if (txq.size() != 2 || dvq.size() != 2) begin
      n_fail++; $display("FAIL rm_fresh_complete: txns=%0d dvalids=%0d want 2 2", txq.size(), dvq.size());
    end else begin
      n_checks++;
      if (txq[0].addr !== 20'h00100 || dvq[0].m != 0 || dvq[0].data !== txq[0].rdata || dvq[1].m != 1) begin
        n_fail++; $display("FAIL rm_first_tie: first addr=%h master=%0d data=%h want 00100 0 %h",
                           txq[0].addr, dvq[0].m, dvq[0].data, txq[0].rdata);
      end
    end
    rr_last = 1'b1;
  endtask

  task automatic test_random();
    op_t           mq [2][$];
    op_t           op;
    bit            wph [2];
    logic [DW-1:0] pwd [2];
    logic [TW-1:0] pwt [2];
    int            j;
    clear_logs();
    rand_delay = 1'b1;
    wph[0] = 1'b0; wph[1] = 1'b0;
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < 2; i++) begin
        m_astb[i] = 1'b0; m_rd[i] = 1'b0; m_wr[i] = 1'b0;
        m_ad[i] = {$urandom, $urandom}; m_tag[i] = 8'($urandom);
        if (wph[i]) begin
          m_ad[i] = pwd[i]; m_tag[i] = pwt[i]; wph[i] = 1'b0;
        end else if (c < 300 && m_wait[i] === 1'b0 && $urandom_range(0, 2) == 0) begin
          op.we = 1'($urandom);
          op.addr = AW'($urandom);
          op.addr[0] = 1'(i);
          op.wdata = {$urandom, $urandom};
          op.wtag = 8'($urandom);
          m_astb[i] = 1'b1; m_rd[i] = !op.we; m_wr[i] = op.we;
          m_ad[i][AW-1:0] = op.addr;
          if (op.we) begin
            wph[i] = 1'b1; pwd[i] = op.wdata; pwt[i] = op.wtag;
          end
          mq[i].push_back(op);
        end else if (c < 300 && $urandom_range(0, 5) == 0) begin
          // Junk strobe: malformed op while free, or any op while stalled.
          m_astb[i] = 1'b1;
          m_rd[i] = 1'($urandom);
          m_wr[i] = (m_wait[i] === 1'b1) ? !m_rd[i] : m_rd[i];
        end
      end
      step();
    end
    j = 0;
    foreach (txq[k]) begin
      int m;
      m = int'(txq[k].addr[0]);
      n_checks++;
      if (mq[m].size() == 0) begin
        n_fail++; $display("FAIL rnd_unexpected_txn: addr=%h from master %0d with empty queue", txq[k].addr, m);
      end else begin
        op = mq[m].pop_front();
        if (txq[k].we !== op.we || txq[k].addr !== op.addr || !txq[k].stable ||
            (op.we && (txq[k].wdata !== op.wdata || txq[k].wtag !== op.wtag))) begin
          n_fail++; $display("FAIL rnd_txn: we=%b addr=%h wdata=%h wtag=%h stable=%0d want %b %h %h %h 1",
                             txq[k].we, txq[k].addr, txq[k].wdata, txq[k].wtag, txq[k].stable,
                             op.we, op.addr, op.wdata, op.wtag);
        end
        if (!op.we) begin
          n_checks++;
          if (j >= dvq.size()) begin
            n_fail++; $display("FAIL rnd_dv_missing: read %h returned no dvalid", op.addr);
          end else if (dvq[j].m != m || dvq[j].data !== txq[k].rdata || dvq[j].tag !== txq[k].rtag ||
                       dvq[j].cycle != txq[k].ack_cycle + 1) begin
            n_fail++; $display("FAIL rnd_dv: master=%0d data=%h tag=%h cycle=%0d want %0d %h %h %0d",
                               dvq[j].m, dvq[j].data, dvq[j].tag, dvq[j].cycle,
                               m, txq[k].rdata, txq[k].rtag, txq[k].ack_cycle + 1);
          end
          j++;
        end
      end
    end
    n_checks++;
    if (mq[0].size() + mq[1].size() != 0 || j != dvq.size()) begin
      n_fail++; $display("FAIL rnd_leftover: unserved=%0d dvalids=%0d want 0 %0d",
                         mq[0].size() + mq[1].size(), dvq.size(), j);
    end
    rand_delay = 1'b0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_read_zero_wait();
    test_write_delayed();
    test_round_robin();
    test_ignored();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
